// File: rtl/wave_trig_reader_if.sv
// Bus bundle for wave_trig_reader: frame-ready strobe, sample RAM read
// port, column stream with valid/ready handshake, and status flags.
// The master modport is the reader itself; the slave modport is the
// surrounding system (RAM, producer and display consumer).
interface wave_trig_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_LEN    = 1920,
    parameter int H_PIXELS   = 1280,
    parameter int V_PIXELS   = 720
);
    localparam int AW = $clog2(BUF_LEN);
    localparam int XW = $clog2(H_PIXELS);
    localparam int YW = $clog2(V_PIXELS);

    logic                         buf_ready;
    logic [AW-1:0]                rd_addr;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic                         col_valid;
    logic                         col_ready;
    logic [XW-1:0]                col_idx;
    logic [YW-1:0]                col_y;
    logic                         col_last;
    logic                         trig_found;
    logic                         overrun;

    modport master (
        input  buf_ready, rd_data, col_ready,
        output rd_addr, col_valid, col_idx, col_y, col_last, trig_found, overrun
    );

    modport slave (
        output buf_ready, rd_data, col_ready,
        input  rd_addr, col_valid, col_idx, col_y, col_last, trig_found, overrun
    );
endinterface

// File: rtl/wave_trig_reader.sv
// wave_trig_reader: after each captured sample frame, searches the start of
// the buffer for the first rising zero crossing, then streams H_PIXELS plot
// columns starting at that trigger offset. Each column's row is the sample
// scaled by an arithmetic shift, mirrored about mid-screen and clamped to
// the display height.
//
// Optional feature: define WAVE_TRIG_HYST_EN to require the waveform to dip
// to -HYST_LVL or below before a zero crossing counts as a trigger. With the
// macro undefined any negative-to-non-negative step triggers.
module wave_trig_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_LEN    = 1920,
    parameter int H_PIXELS   = 1280,
    parameter int V_PIXELS   = 720,
    parameter int SEARCH_LEN = 640,
    parameter int Y_SHIFT    = 7,
    parameter int HYST_LVL   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    wave_trig_reader_if.master bus
);
    localparam int AW      = $clog2(BUF_LEN);
    localparam int XW      = $clog2(H_PIXELS);
    localparam int YW      = $clog2(V_PIXELS);
    localparam int MAX_CNT = (SEARCH_LEN > H_PIXELS) ? SEARCH_LEN : H_PIXELS;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int EW      = DATA_WIDTH + 2;

    localparam logic [AW-1:0]        ADDR_LAST  = AW'(BUF_LEN - 1);
    localparam logic [CW-1:0]        CNT_SEARCH = CW'(SEARCH_LEN);
    localparam logic [CW-1:0]        CNT_H      = CW'(H_PIXELS);
    localparam logic [CW-1:0]        IDX_SLAST  = CW'(SEARCH_LEN - 1);
    localparam logic [CW-1:0]        IDX_HLAST  = CW'(H_PIXELS - 1);
    localparam logic signed [EW-1:0] Y_MID      = EW'(V_PIXELS / 2);
    localparam logic signed [EW-1:0] Y_MAX      = EW'(V_PIXELS - 1);

    // A trigger window plus a full screen must fit in the buffer.
    if ((SEARCH_LEN + H_PIXELS > BUF_LEN) || (HYST_LVL < 0)) begin : g_bad_cfg
        $error("wave_trig_reader: inconsistent parameters");
    end

    typedef enum logic [1:0] {IDLE, SEARCH, SCAN, DONE} state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_rst_meta;
    logic            r_rst_sync;
    logic            w_rst_n;

    logic [AW-1:0]   r_rd_addr;
    logic [CW-1:0]   r_cnt;
    logic            r_pend;
    logic [CW-1:0]   r_pend_idx;
    logic            r_prev_neg;
    logic            r_trig;

    logic            r_col_valid;
    logic [XW-1:0]   r_col_idx;
    logic [YW-1:0]   r_col_y;
    logic            r_col_last;
    logic            r_skid_valid;
    logic [XW-1:0]   r_skid_idx;
    logic [YW-1:0]   r_skid_y;
    logic            r_skid_last;

    logic            w_issue;
    logic            w_search_done;
    logic            w_pop;
    logic            w_room;
    logic [1:0]      w_occ;
    logic [AW-1:0]   w_addr_inc;
    logic            w_nonneg;
    logic            w_edge;
    logic            w_window_end;
    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_shift;
    logic signed [EW-1:0] w_yraw;
    logic [YW-1:0]   w_ysat;
    logic [XW-1:0]   w_in_idx;
    logic            w_in_last;

`ifdef WAVE_TRIG_HYST_EN
    localparam logic signed [EW-1:0] HYST_NEG = -EW'(HYST_LVL);
    logic            r_armed;
    logic            w_deep;
`endif

    // Reset asserts immediately but releases only after two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    assign w_ext      = {{2{bus.rd_data[DATA_WIDTH-1]}}, bus.rd_data};
    assign w_shift    = w_ext >>> Y_SHIFT;
    assign w_yraw     = Y_MID - w_shift;
    assign w_nonneg   = ~bus.rd_data[DATA_WIDTH-1];
    assign w_addr_inc = (r_rd_addr == ADDR_LAST) ? '0 : r_rd_addr + 1'b1;
    assign w_in_idx   = XW'(r_pend_idx);
    assign w_in_last  = (r_pend_idx == IDX_HLAST);

    assign w_pop  = r_col_valid & bus.col_ready;
    assign w_occ  = {1'b0, r_col_valid} + {1'b0, r_skid_valid} + {1'b0, r_pend};
    assign w_room = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);

`ifdef WAVE_TRIG_HYST_EN
    assign w_deep = (w_ext <= HYST_NEG);
    assign w_edge = r_pend & r_prev_neg & w_nonneg & r_armed;
`else
    assign w_edge = r_pend & r_prev_neg & w_nonneg;
`endif
    assign w_window_end = r_pend & (r_pend_idx == IDX_SLAST);

    // Clamp the mirrored, scaled sample into the visible row range.
    always_comb begin
        w_ysat = YW'(w_yraw);
        if (w_yraw < 0) begin
            w_ysat = '0;
        end else if (w_yraw > Y_MAX) begin
            w_ysat = YW'(Y_MAX);
        end
    end

    // Frame sequencing state register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and read-issue decisions; a scan read is only issued when
    // the output register plus skid slot can absorb its returning data.
    always_comb begin
        w_next        = r_state;
        w_issue       = 1'b0;
        w_search_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.buf_ready) begin
                    w_next = SEARCH;
                end
            end
            SEARCH: begin
                w_search_done = w_edge | w_window_end;
                w_issue       = (r_cnt < CNT_SEARCH) & ~w_search_done;
                if (w_search_done) begin
                    w_next = SCAN;
                end
            end
            SCAN: begin
                w_issue = (r_cnt < CNT_H) & w_room;
                if (w_pop && r_col_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Address generation, trigger detection and the column output/skid pair.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_addr    <= '0;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_pend_idx   <= '0;
            r_prev_neg   <= 1'b0;
            r_trig       <= 1'b0;
            r_col_valid  <= 1'b0;
            r_col_idx    <= '0;
            r_col_y      <= '0;
            r_col_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_idx   <= '0;
            r_skid_y     <= '0;
            r_skid_last  <= 1'b0;
`ifdef WAVE_TRIG_HYST_EN
            r_armed      <= 1'b0;
`endif
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_idx <= r_cnt;
                r_cnt      <= r_cnt + 1'b1;
                r_rd_addr  <= w_addr_inc;
            end
            case (r_state)
                IDLE: begin
                    if (bus.buf_ready) begin
                        r_rd_addr  <= '0;
                        r_cnt      <= '0;
                        r_prev_neg <= 1'b0;
                        r_trig     <= 1'b0;
`ifdef WAVE_TRIG_HYST_EN
                        r_armed    <= 1'b0;
`endif
                    end
                end
                SEARCH: begin
                    if (r_pend) begin
                        r_prev_neg <= ~w_nonneg;
`ifdef WAVE_TRIG_HYST_EN
                        if (w_nonneg) begin
                            r_armed <= 1'b0;
                        end else if (w_deep) begin
                            r_armed <= 1'b1;
                        end
`endif
                    end
                    if (w_search_done) begin
                        r_trig    <= w_edge;
                        r_rd_addr <= w_edge ? AW'(r_pend_idx) : '0;
                        r_cnt     <= '0;
                    end
                end
                SCAN: begin
                    if (!r_col_valid || w_pop) begin
                        if (r_skid_valid) begin
                            r_col_valid <= 1'b1;
                            r_col_idx   <= r_skid_idx;
                            r_col_y     <= r_skid_y;
                            r_col_last  <= r_skid_last;
                            if (r_pend) begin
                                r_skid_idx  <= w_in_idx;
                                r_skid_y    <= w_ysat;
                                r_skid_last <= w_in_last;
                            end else begin
                                r_skid_valid <= 1'b0;
                            end
                        end else if (r_pend) begin
                            r_col_valid <= 1'b1;
                            r_col_idx   <= w_in_idx;
                            r_col_y     <= w_ysat;
                            r_col_last  <= w_in_last;
                        end else begin
                            r_col_valid <= 1'b0;
                        end
                    end else if (r_pend) begin
                        r_skid_valid <= 1'b1;
                        r_skid_idx   <= w_in_idx;
                        r_skid_y     <= w_ysat;
                        r_skid_last  <= w_in_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_addr    = r_rd_addr;
    assign bus.col_valid  = r_col_valid;
    assign bus.col_idx    = r_col_idx;
    assign bus.col_y      = r_col_y;
    assign bus.col_last   = r_col_last;
    assign bus.trig_found = r_trig;
    assign bus.overrun    = bus.buf_ready & (r_state != IDLE);
endmodule
